mac_operand_source: RTL and testbench

- Stream transmitter that feeds one operand port (a, b or c) of the MAC engine.
- Reads `len` 32-bit words from the TCDM at base + k*stride and emits them in order as a ready/valid HWPE-Stream.
- One instance per operand stream, driven by the accelerator controller through start/done.
- A credit-controlled internal FIFO absorbs TCDM responses so stream backpressure never loses data.

---
 rtl/mac_operand_source.sv | 176 +++++++++++++++++
 tb/tb_mac_operand_source.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_source.sv
// mac_operand_source: strided TCDM reader feeding one MAC operand stream.
// Requests are credit-limited so every response always has a FIFO slot.
module mac_operand_source #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  output logic [DATA_WIDTH/8-1:0] stream_strb_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW:0] DEPTH_W = (OW+1)'(FIFO_DEPTH);
  localparam logic [OW-1:0] FULL_W = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  gcnt_q, gcnt_d;
  logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic [OW-1:0]         fcnt_q, fcnt_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  done_q, done_d;
  logic                  flush_q;

  logic       req;
  logic       gnt;
  logic       push;
  logic       pop;
  logic [OW:0] credit;

  // A stale response after a flush finds outstanding at zero and is dropped.
  assign credit = {1'b0, fcnt_q} + {1'b0, outst_q};
  assign req    = (state_q == RUN) && (credit < DEPTH_W);
  assign gnt    = req && tcdm_gnt_i;
  assign push   = tcdm_r_valid_i && (outst_q != '0);
  assign pop    = (fcnt_q != '0) && stream_ready_i;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    gcnt_d   = gcnt_q;
    bcnt_d   = bcnt_q;
    done_d   = 1'b0;
    outst_d  = outst_q + OW'(gnt) - OW'(push);
    fcnt_d   = fcnt_q + OW'(push) - OW'(pop);
    wptr_d   = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = pop ? rptr_q + PW'(1) : rptr_q;
    if (gnt) begin
      addr_d = addr_q + stride_q;
      gcnt_d = gcnt_q + CNT_WIDTH'(1);
    end
    if (pop) begin
      bcnt_d = bcnt_q + CNT_WIDTH'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          stride_d = stride_i;
          len_d    = len_i;
          gcnt_d   = '0;
          bcnt_d   = '0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (gnt && (gcnt_q == len_q - CNT_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (bcnt_q == len_q - CNT_WIDTH'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      gcnt_q   <= '0;
      bcnt_q   <= '0;
      outst_q  <= '0;
      fcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      done_q   <= 1'b0;
      flush_q  <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      gcnt_q   <= gcnt_d;
      bcnt_q   <= bcnt_d;
      outst_q  <= outst_d;
      fcnt_q   <= fcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      done_q   <= done_d;
      flush_q  <= 1'b0;
      if (push) begin
        mem_q[wptr_q] <= tcdm_r_data_i;
      end
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign tcdm_req_o     = req;
  assign tcdm_add_o     = addr_q;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = (fcnt_q != '0);
  assign stream_data_o  = mem_q[rptr_q];
  assign stream_strb_o  = '1;

`ifndef SYNTHESIS
  a_no_full_push: assert property (
    @(posedge clk_i) disable iff (rst_i || clear_i)
    push |-> (fcnt_q != FULL_W));

  a_no_orphan_rvalid: assert property (
    @(posedge clk_i) disable iff (rst_i || clear_i)
    tcdm_r_valid_i |-> ((outst_q != '0) || flush_q));
`endif

endmodule

// File: tb/tb_mac_operand_source.sv
// Bench for mac_operand_source: directed latency scenarios plus
// randomized jobs against an address/credit reference model.
module tb_mac_operand_source;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [AW-1:0]   stride_i = '0;
  logic [CW-1:0]   len_i = '0;
  logic            busy_o;
  logic            done_o;
  logic            tcdm_req_o;
  logic            tcdm_gnt_i = 1'b0;
  logic [AW-1:0]   tcdm_add_o;
  logic            tcdm_wen_o;
  logic [DW/8-1:0] tcdm_be_o;
  logic [DW-1:0]   tcdm_data_o;
  logic [DW-1:0]   tcdm_r_data_i = '0;
  logic            tcdm_r_valid_i = 1'b0;
  logic            stream_valid_o;
  logic            stream_ready_i = 1'b0;
  logic [DW-1:0]   stream_data_o;
  logic [DW/8-1:0] stream_strb_o;

  mac_operand_source #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .clear_i(clear_i),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .stride_i(stride_i),
    .len_i(len_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .tcdm_req_o(tcdm_req_o),
    .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i),
    .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o),
    .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o),
    .stream_strb_o(stream_strb_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic          s_req, s_valid, s_done, s_busy, s_gnt, s_hs;
  logic [AW-1:0] s_add;
  logic [DW-1:0] s_data;
  logic [DW-1:0] key = '0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a ^ key;
  endfunction

  // Samples one cycle at the falling edge, then plays the memory:
  // a grant seen in this cycle is answered in the next one.
  task automatic cycle();
    @(negedge clk);
    s_req   = tcdm_req_o;
    s_add   = tcdm_add_o;
    s_valid = stream_valid_o;
    s_data  = stream_data_o;
    s_done  = done_o;
    s_busy  = busy_o;
    s_gnt   = tcdm_req_o & tcdm_gnt_i;
    s_hs    = stream_valid_o & stream_ready_i;
    @(posedge clk);
    #1;
    tcdm_r_valid_i = s_gnt;
    tcdm_r_data_i  = s_gnt ? memf(s_add) : 32'hDEAD_BEEF;
    start_i = 1'b0;
    clear_i = 1'b0;
    cyc++;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input int n);
    base_addr_i = b;
    stride_i    = s;
    len_i       = CW'(n);
    start_i     = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cycle();
    cycle();
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %0b exp 0", s_req);
    end
    checks++;
    if (s_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", s_valid);
    end
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done got %0b%0b exp 00", s_busy, s_done);
    end
    checks++;
    if (tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF || tcdm_data_o !== '0
        || stream_strb_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_consts got wen=%0b be=%h d=%h strb=%h exp 1 f 0 f",
               tcdm_wen_o, tcdm_be_o, tcdm_data_o, stream_strb_o);
    end
    rst_i = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    logic          er, ev, ed, eb;
    logic [AW-1:0] ea;
    key = '0;
    tcdm_gnt_i = 1'b1;
    stream_ready_i = 1'b1;
    launch(32'h100, 32'h4, 4);
    for (int c = 0; c <= 8; c++) begin
      cycle();
      er = (c >= 1 && c <= 4);
      ev = (c >= 3 && c <= 6);
      ed = (c == 7);
      eb = (c >= 1 && c <= 6);
      checks++;
      if (s_req !== er) begin
        errors++; $display("FAIL basic_req c%0d got %0b exp %0b", c, s_req, er);
      end
      if (er) begin
        ea = 32'h100 + AW'(4 * (c - 1));
        checks++;
        if (s_add !== ea) begin
          errors++; $display("FAIL basic_add c%0d got %h exp %h", c, s_add, ea);
        end
      end
      checks++;
      if (s_valid !== ev) begin
        errors++; $display("FAIL basic_valid c%0d got %0b exp %0b", c, s_valid, ev);
      end
      if (ev) begin
        ea = 32'h100 + AW'(4 * (c - 3));
        checks++;
        if (s_data !== ea) begin
          errors++; $display("FAIL basic_data c%0d got %h exp %h", c, s_data, ea);
        end
      end
      checks++;
      if (s_done !== ed || s_busy !== eb) begin
        errors++;
        $display("FAIL basic_done_busy c%0d got %0b%0b exp %0b%0b",
                 c, s_done, s_busy, ed, eb);
      end
    end
  endtask

  task automatic test_backpressure();
    int            ng = 0;
    int            nd = 0;
    logic [DW-1:0] beats[$];
    key = '0;
    tcdm_gnt_i = 1'b1;
    stream_ready_i = 1'b0;
    launch(32'h100, 32'h4, 8);
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (s_gnt) ng++;
      if (c >= 3) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== 32'h100) begin
          errors++;
          $display("FAIL bp_hold c%0d got v=%0b d=%h exp v=1 d=00000100",
                   c, s_valid, s_data);
        end
      end
    end
    checks++;
    if (ng !== 4 || s_req !== 1'b0) begin
      errors++; $display("FAIL bp_credit got grants=%0d req=%0b exp 4 0", ng, s_req);
    end
    stream_ready_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (s_gnt) ng++;
      if (s_hs) beats.push_back(s_data);
      if (s_done) nd++;
    end
    checks++;
    if (ng !== 8 || beats.size() !== 8 || nd !== 1) begin
      errors++;
      $display("FAIL bp_totals got g=%0d b=%0d d=%0d exp 8 8 1", ng, beats.size(), nd);
    end
    for (int k = 0; k < beats.size(); k++) begin
      checks++;
      if (beats[k] !== 32'h100 + AW'(4 * k)) begin
        errors++;
        $display("FAIL bp_order k%0d got %h exp %h", k, beats[k], 32'h100 + AW'(4 * k));
      end
    end
  endtask

  task automatic test_grant_stall();
    int            first = -1;
    int            nb = 0;
    int            nd = 0;
    logic [DW-1:0] fd = '0;
    key = '0;
    stream_ready_i = 1'b1;
    launch(32'h100, 32'h4, 2);
    for (int c = 0; c < 13; c++) begin
      tcdm_gnt_i = (c >= 4);
      cycle();
      if (c >= 1 && c <= 4) begin
        checks++;
        if (s_req !== 1'b1 || s_add !== 32'h100) begin
          errors++;
          $display("FAIL stall_req c%0d got req=%0b a=%h exp 1 00000100", c, s_req, s_add);
        end
      end
      if (s_hs) begin
        if (first < 0) begin
          first = c;
          fd = s_data;
        end
        nb++;
      end
      if (s_done) nd++;
    end
    checks++;
    if (first !== 6 || fd !== 32'h100) begin
      errors++; $display("FAIL stall_first got c%0d d=%h exp c6 00000100", first, fd);
    end
    checks++;
    if (nb !== 2 || nd !== 1) begin
      errors++; $display("FAIL stall_totals got b=%0d d=%0d exp 2 1", nb, nd);
    end
  endtask

  task automatic test_zero_len();
    tcdm_gnt_i = 1'b1;
    stream_ready_i = 1'b1;
    launch(32'h40, 32'h4, 0);
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if (s_done !== (c == 1)) begin
        errors++; $display("FAIL zero_done c%0d got %0b exp %0b", c, s_done, (c == 1));
      end
      checks++;
      if (s_req !== 1'b0 || s_busy !== 1'b0) begin
        errors++; $display("FAIL zero_idle c%0d got req=%0b busy=%0b exp 0 0", c, s_req, s_busy);
      end
    end
  endtask

  task automatic test_neg_stride();
    logic [AW-1:0] exp_a[3];
    logic [AW-1:0] ga[$];
    logic [DW-1:0] bd[$];
    exp_a[0] = 32'h4;
    exp_a[1] = 32'h0;
    exp_a[2] = 32'hFFFF_FFFC;
    key = 32'h0F0F_0000;
    tcdm_gnt_i = 1'b1;
    stream_ready_i = 1'b1;
    launch(32'h4, 32'hFFFF_FFFC, 3);
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (s_gnt) ga.push_back(s_add);
      if (s_hs) bd.push_back(s_data);
    end
    checks++;
    if (ga.size() !== 3 || bd.size() !== 3) begin
      errors++; $display("FAIL neg_counts got g=%0d b=%0d exp 3 3", ga.size(), bd.size());
    end
    for (int k = 0; k < 3 && k < ga.size() && k < bd.size(); k++) begin
      checks++;
      if (ga[k] !== exp_a[k] || bd[k] !== memf(exp_a[k])) begin
        errors++;
        $display("FAIL neg_wrap k%0d got a=%h d=%h exp a=%h d=%h",
                 k, ga[k], bd[k], exp_a[k], memf(exp_a[k]));
      end
    end
  endtask

  task automatic test_clear();
    int            ng = 0;
    int            nd = 0;
    logic [DW-1:0] bd[$];
    key = '0;
    tcdm_gnt_i = 1'b1;
    stream_ready_i = 1'b1;
    launch(32'h100, 32'h4, 8);
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (s_gnt) ng++;
    end
    checks++;
    if (ng !== 3) begin
      errors++; $display("FAIL clr_pre got grants=%0d exp 3", ng);
    end
    clear_i = 1'b1;
    cycle();
    cycle();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_state got req=%0b v=%0b busy=%0b done=%0b exp 0000",
               s_req, s_valid, s_busy, s_done);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_done !== 1'b0) begin
        errors++; $display("FAIL clr_quiet got v=%0b done=%0b exp 0 0", s_valid, s_done);
      end
    end
    launch(32'h200, 32'h4, 2);
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (s_hs) bd.push_back(s_data);
      if (s_done) nd++;
    end
    checks++;
    if (bd.size() !== 2 || nd !== 1) begin
      errors++; $display("FAIL clr_rejob got b=%0d d=%0d exp 2 1", bd.size(), nd);
    end else begin
      checks++;
      if (bd[0] !== 32'h200 || bd[1] !== 32'h204) begin
        errors++; $display("FAIL clr_data got %h %h exp 00000200 00000204", bd[0], bd[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ea;
    key = '0;
    tcdm_gnt_i = 1'b1;
    stream_ready_i = 1'b1;
    launch(32'h100, 32'h4, 2);
    for (int c = 0; c <= 12; c++) begin
      if (c == 5) launch(32'h300, 32'h8, 3);
      cycle();
      checks++;
      if (s_done !== (c == 5 || c == 11)) begin
        errors++; $display("FAIL b2b_done c%0d got %0b exp %0b", c, s_done, (c == 5 || c == 11));
      end
      if (c >= 8 && c <= 10) begin
        ea = 32'h300 + AW'(8 * (c - 8));
        checks++;
        if (s_valid !== 1'b1 || s_data !== ea) begin
          errors++;
          $display("FAIL b2b_beat c%0d got v=%0b d=%h exp 1 %h", c, s_valid, s_data, ea);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] q[$];
    logic [AW-1:0] a, base, stride;
    int            len, gp, rp, ng, nb, pg;
    logic          dn, fin, er, ev;
    for (int j = 0; j < 24; j++) begin
      key  = $urandom;
      base = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0: stride = 32'h4;
        1: stride = 32'hFFFF_FFFC;
        2: stride = $urandom & 32'h0000_0FFC;
        default: stride = $urandom & 32'hFFFF_FFFC;
      endcase
      len = $urandom_range(1, 20);
      gp  = $urandom_range(25, 100);
      rp  = $urandom_range(25, 100);
      q.delete();
      a = base;
      for (int k = 0; k < len; k++) begin
        q.push_back(a);
        a = a + stride;
      end
      tcdm_gnt_i = ($urandom_range(1, 100) <= gp);
      stream_ready_i = ($urandom_range(1, 100) <= rp);
      launch(base, stride, len);
      cycle();
      ng = 0; nb = 0; pg = 0; dn = 1'b0; fin = 1'b0;
      for (int c = 1; c < 600 && !fin; c++) begin
        tcdm_gnt_i = ($urandom_range(1, 100) <= gp);
        stream_ready_i = ($urandom_range(1, 100) <= rp);
        if (nb < len && $urandom_range(0, 15) == 0) begin
          base_addr_i = $urandom;
          len_i = CW'($urandom_range(0, 50));
          start_i = 1'b1;
        end
        cycle();
        checks++;
        if (s_done !== dn || s_busy !== !dn) begin
          errors++;
          $display("FAIL rnd_done j%0d c%0d got d=%0b b=%0b exp d=%0b", j, c, s_done, s_busy, dn);
        end
        if (dn) begin
          fin = 1'b1;
        end else begin
          er = (ng < len) && (ng - nb < DEPTH);
          ev = (ng - pg - nb) > 0;
          checks++;
          if (s_req !== er) begin
            errors++;
            $display("FAIL rnd_req j%0d c%0d got %0b exp %0b g=%0d b=%0d", j, c, s_req, er, ng, nb);
          end
          if (s_gnt && ng < len) begin
            checks++;
            if (s_add !== q[ng]) begin
              errors++; $display("FAIL rnd_add j%0d k%0d got %h exp %h", j, ng, s_add, q[ng]);
            end
          end
          checks++;
          if (s_valid !== ev) begin
            errors++; $display("FAIL rnd_valid j%0d c%0d got %0b exp %0b", j, c, s_valid, ev);
          end
          if (s_valid && ev && nb < len) begin
            checks++;
            if (s_data !== memf(q[nb])) begin
              errors++;
              $display("FAIL rnd_data j%0d k%0d got %h exp %h", j, nb, s_data, memf(q[nb]));
            end
          end
          pg = s_gnt ? 1 : 0;
          ng = ng + pg;
          if (s_hs) nb++;
          if (nb == len) dn = 1'b1;
        end
      end
      if (!fin) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout j%0d got beats=%0d exp %0d", j, nb, len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_grant_stall();
    test_zero_len();
    test_neg_stride();
    test_clear();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
